i2c_cmd_sequencer: RTL and testbench
====================================

# i2c_cmd_sequencer

Command sequencer that drives the single-byte-write I2C master from an external command ROM, used to bring up the flight sensors after reset. On `go` it fetches 16-bit commands, issues each as one master transaction (start/busy/error handshake), inserts a bus-idle gap between transactions, and retries failed writes by pulsing the master's reset. It sits between the board bring-up logic and the I2C master. It reports completion with `done`, or with `fail` plus the failing command index.

## Interface
- `NUM_CMDS`, 16: command table depth; index `NUM_CMDS-1` is always treated as last.
- `ADDR_W`, 4: command index width; must satisfy `2**ADDR_W >= NUM_CMDS`.
- `RETRY_MAX`, 3: retries per command after the first attempt.
- `GAP_CYCLES`, 500: idle clocks between transactions.
- `BUSY_TIMEOUT`, 65535: maximum clocks spent in any one wait state.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `go` in 1: start pulse; accepted only in IDLE, DONE or FAIL.
- `cmd_addr` out ADDR_W: ROM read index (registered).
- `cmd_data` in 16: ROM data, valid one clock after `cmd_addr`. Fields: [15] last, [14:8] slave addr, [7:0] data byte.
- `m_start` out 1: one-cycle start to the master.
- `m_slave_addr` out 7: slave address to the master.
- `m_data` out 8: data byte to the master.
- `m_rst` out 1: active-high reset to the master, used for error recovery.
- `m_busy` in 1: master busy flag.
- `m_error` in 1: master error flag (sticky until master reset).
- `active` out 1: high in every state except IDLE, DONE and FAIL.
- `done` out 1: level; the sequence completed.
- `fail` out 1: level; the retry budget is exhausted.
- `fail_index` out ADDR_W: index of the failing command.

## Operation
- States and transitions:
  - IDLE: `go` → FETCH.
  - FETCH: drive `cmd_addr` → LOAD.
  - LOAD: capture `cmd_data` into `m_slave_addr`, `m_data` and the last flag; clear retry count → ISSUE.
  - ISSUE: `m_start`=1 for this cycle only → WAIT_BUSY.
  - WAIT_BUSY: `m_busy`=1 → WAIT_DONE.
  - WAIT_DONE:
    - `m_error`=1 → RECOVER. `m_error` has priority over `m_busy` in the same cycle.
    - `m_busy`=0 → on last command, DONE; otherwise GAP.
  - A timeout in WAIT_BUSY or WAIT_DONE is treated as an error.
  - RECOVER: `m_rst`=1 for exactly 2 cycles.
    - If retry count < RETRY_MAX: increment it → GAP with the retry flag set.
    - Otherwise → FAIL, with `fail_index` = current index.
  - GAP: count GAP_CYCLES.
    - Retry flag set → ISSUE, re-using the loaded command; no refetch.
    - Otherwise increment the index → FETCH.
  - DONE / FAIL: hold; `go` → FETCH with index 0, and clears `done`/`fail`.
- A command is last if bit[15]=1 or its index is `NUM_CMDS-1`. The index never wraps.
- `go` in any other state is ignored.
- `m_slave_addr`/`m_data` change only in LOAD.
- The wait-state timeout counter clears on entry to each wait state. It saturates at BUSY_TIMEOUT, and reaching BUSY_TIMEOUT is the timeout.

## Timing
- Reset values: state IDLE; `cmd_addr`=0, `m_start`=0, `m_slave_addr`=0, `m_data`=0, `m_rst`=0, `active`=0, `done`=0, `fail`=0, `fail_index`=0. Counters 0.
- Asserting `rst_n` low mid-transaction aborts immediately to the reset values. `m_rst` is not asserted in that case; the master shares the system reset.
- Start-up latency: `go` sampled in cycle N puts FETCH in N+1, LOAD in N+2 and `m_start` in N+3.
- The master raises `m_busy` two cycles after `m_start`. WAIT_BUSY tolerates any delay up to BUSY_TIMEOUT.
- Success to next start: 1 (WAIT_DONE exit) + GAP_CYCLES + 3 (FETCH, LOAD, ISSUE) cycles.
- `done`/`fail` assert in the cycle DONE/FAIL is entered.

## Configuration
- Macro `I2C_SEQ_RETRY_EN`:
  - Defined: retry behaviour as above.
  - Undefined: RECOVER still pulses `m_rst` for 2 cycles but always goes to FAIL. RETRY_MAX is ignored and no retry counter is synthesised.

## Test plan
- Three commands, last flag on index 2, master model always ACKs → exactly 3 `m_start` pulses with matching addr/data, ≥GAP_CYCLES between transactions, `done`=1, `fail`=0.
- Index 1 errors twice then succeeds (`I2C_SEQ_RETRY_EN` defined, RETRY_MAX=3) → two 2-cycle `m_rst` pulses, index 1 issued 3 times, then `done`=1.
- Index 4 always errors → 1+RETRY_MAX attempts, then `fail`=1, `fail_index`=4, `active`=0. Without the macro: one attempt, then `fail`=1.
- Master never raises `m_busy` → timeout after BUSY_TIMEOUT cycles, handled as an error.
- `go` pulsed mid-sequence is ignored. `rst_n` low during WAIT_DONE → all outputs at reset values next cycle. A fresh `go` restarts at index 0.
- No last flag in the table → sequence ends after index NUM_CMDS-1 with `done`=1; `cmd_addr` never exceeds NUM_CMDS-1.

Source files
------------

// File: rtl/i2c_cmd_sequencer_if.sv
// i2c_cmd_sequencer_if: command ROM, I2C master handshake and status signals of the sequencer
interface i2c_cmd_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              go;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_data;
    logic              m_start;
    logic [6:0]        m_slave_addr;
    logic [7:0]        m_data;
    logic              m_rst;
    logic              m_busy;
    logic              m_error;
    logic              active;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_index;

    modport master (
        input  go, cmd_data, m_busy, m_error,
        output cmd_addr, m_start, m_slave_addr, m_data, m_rst, active, done, fail, fail_index
    );

    modport slave (
        output go, cmd_data, m_busy, m_error,
        input  cmd_addr, m_start, m_slave_addr, m_data, m_rst, active, done, fail, fail_index
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: plays a command ROM into a single-byte-write I2C master; retries enabled by I2C_SEQ_RETRY_EN
module i2c_cmd_sequencer #(
    parameter int NUM_CMDS     = 16,
    parameter int ADDR_W       = 4,
    parameter int RETRY_MAX    = 3,
    parameter int GAP_CYCLES   = 500,
    parameter int BUSY_TIMEOUT = 65535
) (
    input logic                  clk,
    input logic                  rst_n,
    i2c_cmd_sequencer_if.master  bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, RECOVER, GAP, DONE, FAIL
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] fail_idx;
    logic [6:0]        slave_addr;
    logic [7:0]        data;
    logic              last;
    logic              retry;
    logic              rec_cnt;
    logic [TW-1:0]     to_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              waiting;
    logic              timeout;
    logic              gap_end;
    logic              rec_end;
    logic              can_retry;

    assign waiting = state inside {WAIT_BUSY, WAIT_DONE};
    assign timeout = to_cnt == TW'(BUSY_TIMEOUT);
    assign gap_end = gap_cnt == GW'(GAP_CYCLES - 1);
    assign rec_end = state == RECOVER && rec_cnt;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RW = $clog2(RETRY_MAX + 2);
    logic [RW-1:0] retry_cnt;

    assign can_retry = retry_cnt < RW'(RETRY_MAX);

    // retry budget for the loaded command, restarted on every fresh load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_cnt <= '0;
        else if (state == LOAD)
            retry_cnt <= '0;
        else if (rec_end && can_retry)
            retry_cnt <= retry_cnt + 1'b1;
    end
`else
    // retries disabled: every recovery ends the sequence, whatever RETRY_MAX says
    assign can_retry = RETRY_MAX < 0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic; a wait-state timeout is handled exactly like a master error
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, FAIL: if (bus.go) state_nx = FETCH;
            FETCH:            state_nx = LOAD;
            LOAD:             state_nx = ISSUE;
            ISSUE:            state_nx = WAIT_BUSY;
            WAIT_BUSY:        if (bus.m_busy) state_nx = WAIT_DONE;
                              else if (timeout) state_nx = RECOVER;
            WAIT_DONE:        if (bus.m_error || timeout) state_nx = RECOVER;
                              else if (!bus.m_busy) state_nx = last ? DONE : GAP;
            RECOVER:          if (rec_cnt) state_nx = can_retry ? GAP : FAIL;
            GAP:              if (gap_end) state_nx = retry ? ISSUE : FETCH;
            default:          state_nx = IDLE;
        endcase
    end

    // wait, gap and recovery counters; the wait counter restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            gap_cnt <= '0;
            rec_cnt <= 1'b0;
        end else begin
            if (!waiting || state_nx != state)
                to_cnt <= '0;
            else if (!timeout)
                to_cnt <= to_cnt + 1'b1;
            gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
            rec_cnt <= state == RECOVER && !rec_cnt;
        end
    end

    // command index, loaded command fields, retry flag and failing index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            slave_addr <= '0;
            data       <= '0;
            last       <= 1'b0;
            retry      <= 1'b0;
            fail_idx   <= '0;
        end else begin
            if (state inside {IDLE, DONE, FAIL} && bus.go)
                idx <= '0;
            else if (state == GAP && gap_end && !retry)
                idx <= idx + 1'b1;
            if (state == LOAD) begin
                slave_addr <= bus.cmd_data[14:8];
                data       <= bus.cmd_data[7:0];
                last       <= bus.cmd_data[15] || idx == ADDR_W'(NUM_CMDS - 1);
            end
            if (rec_end && can_retry)
                retry <= 1'b1;
            else if (state == GAP && gap_end)
                retry <= 1'b0;
            if (rec_end && !can_retry)
                fail_idx <= idx;
        end
    end

    assign bus.cmd_addr     = idx;
    assign bus.m_start      = state == ISSUE;
    assign bus.m_slave_addr = slave_addr;
    assign bus.m_data       = data;
    assign bus.m_rst        = state == RECOVER;
    assign bus.active       = !(state inside {IDLE, DONE, FAIL});
    assign bus.done         = state == DONE;
    assign bus.fail         = state == FAIL;
    assign bus.fail_index   = fail_idx;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: randomized command tables and a reactive master model checked against a sequence-level reference
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;
    localparam int NUM  = 12;
    localparam int AW   = 4;
    localparam int RMAX = 3;
    localparam int GAP  = 20;
    localparam int TMO  = 60;
`ifdef I2C_SEQ_RETRY_EN
    localparam int RMAX_EFF = RMAX;
`else
    localparam int RMAX_EFF = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if #(.ADDR_W(AW)) bus ();

    i2c_cmd_sequencer #(
        .NUM_CMDS(NUM), .ADDR_W(AW), .RETRY_MAX(RMAX), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [15:0] rom [NUM];
    int          err_plan [NUM];
    int          att [NUM];
    bit          never_busy;
    int          seq_id, last_seq;
    int          checks, fails;

    logic [14:0] issued [$];
    logic [14:0] exp_q [$];
    bit          exp_done, exp_fail;
    int          exp_fidx, exp_rst;
    int          base_iss, base_rst, rst_pulses;

    time ok_t, rst_t, go_t, start_t, first_start_t, ref_t;
    int  phase, t, hold, rst_len, gap, exp_gap;
    bit  err_this, prev_start;

    // synchronous command ROM: data follows the address by one clock
    always @(posedge clk) bus.cmd_data <= rom[bus.cmd_addr];

    // reference: what the sequence must issue, derived from the table and the per-index error plan
    function automatic void build_model();
        exp_q.delete();
        exp_done = 0; exp_fail = 0; exp_fidx = 0; exp_rst = 0;
        for (int i = 0; i < NUM; i++) begin
            int tries = (err_plan[i] > RMAX_EFF) ? RMAX_EFF + 1 : err_plan[i] + 1;
            repeat (tries) exp_q.push_back(rom[i][14:0]);
            exp_rst += (err_plan[i] > RMAX_EFF) ? RMAX_EFF + 1 : err_plan[i];
            if (err_plan[i] > RMAX_EFF) begin
                exp_fail = 1; exp_fidx = i;
                return;
            end
            if (rom[i][15] || i == NUM - 1) begin
                exp_done = 1;
                return;
            end
        end
    endfunction

    function automatic int first_diff(int base);
        if (issued.size() - base != exp_q.size()) return 999;
        foreach (exp_q[i]) if (issued[base + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < NUM; i++) begin
            rom[i] = {1'b0, 15'($urandom)};
            err_plan[i] = 0;
        end
    endtask

    task automatic run_seq();
        seq_id++;
        base_iss = issued.size();
        base_rst = rst_pulses;
        @(negedge clk);
        bus.go = 1'b1;
        go_t = $time;
        @(negedge clk);
        bus.go = 1'b0;
        for (int i = 0; i < 3000 && !(bus.done || bus.fail); i++) @(negedge clk);
        checks++;
        if (!(bus.done || bus.fail)) begin
            fails++;
            $display("FAIL seq_end: done=%b fail=%b after 3000 cycles, required done or fail", bus.done, bus.fail);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.cmd_addr, bus.m_start, bus.m_slave_addr, bus.m_data, bus.m_rst, bus.active,
             bus.done, bus.fail, bus.fail_index} !== 28'h0) begin
            fails++;
            $display("FAIL reset_values: outputs=%h, required 0", {bus.cmd_addr, bus.m_start, bus.m_slave_addr,
                     bus.m_data, bus.m_rst, bus.active, bus.done, bus.fail, bus.fail_index});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cmd_addr, bus.m_start, bus.m_rst, bus.active, bus.done, bus.fail} !== 9'h0) begin
            fails++;
            $display("FAIL idle_values: outputs=%h, required 0",
                     {bus.cmd_addr, bus.m_start, bus.m_rst, bus.active, bus.done, bus.fail});
        end
    endtask

    task automatic test_three_cmds();
        int d;
        fill_rom();
        rom[2][15] = 1'b1;
        build_model();
        run_seq();
        d = first_diff(base_iss);
        checks++;
        if (d != -1) begin fails++; $display("FAIL three_issue: first bad entry %0d of %0d issued, required none", d, issued.size() - base_iss); end
        checks++;
        if ((first_start_t - go_t) / 10 != 3) begin fails++; $display("FAIL start_latency: %0d cycles, required 3", (first_start_t - go_t) / 10); end
        checks++;
        if ({bus.done, bus.fail, bus.active} !== {exp_done, exp_fail, 1'b0}) begin fails++; $display("FAIL three_status: done/fail/active=%b%b%b, required %b%b0", bus.done, bus.fail, bus.active, exp_done, exp_fail); end
        checks++;
        if (rst_pulses - base_rst != exp_rst) begin fails++; $display("FAIL three_rst: %0d m_rst pulses, required %0d", rst_pulses - base_rst, exp_rst); end
    endtask

    task automatic test_retry();
        int d;
        fill_rom();
        rom[3][15] = 1'b1;
        err_plan[1] = 2;
        build_model();
        run_seq();
        d = first_diff(base_iss);
        checks++;
        if (d != -1) begin fails++; $display("FAIL retry_issue: first bad entry %0d of %0d issued, required none", d, issued.size() - base_iss); end
        checks++;
        if ({bus.done, bus.fail, bus.active} !== {exp_done, exp_fail, 1'b0}) begin fails++; $display("FAIL retry_status: done/fail/active=%b%b%b, required %b%b0", bus.done, bus.fail, bus.active, exp_done, exp_fail); end
        checks++;
        if (rst_pulses - base_rst != exp_rst) begin fails++; $display("FAIL retry_rst: %0d m_rst pulses, required %0d", rst_pulses - base_rst, exp_rst); end
    endtask

    task automatic test_always_error();
        int d;
        fill_rom();
        rom[6][15] = 1'b1;
        err_plan[4] = 99;
        build_model();
        run_seq();
        d = first_diff(base_iss);
        checks++;
        if (d != -1) begin fails++; $display("FAIL err_issue: first bad entry %0d of %0d issued, required none", d, issued.size() - base_iss); end
        checks++;
        if ({bus.done, bus.fail, bus.active, bus.fail_index} !== {exp_done, exp_fail, 1'b0, AW'(exp_fidx)}) begin
            fails++;
            $display("FAIL err_status: done/fail/active=%b%b%b index=%0d, required %b%b0 index=%0d", bus.done, bus.fail, bus.active, bus.fail_index, exp_done, exp_fail, exp_fidx);
        end
        checks++;
        if (rst_pulses - base_rst != exp_rst) begin fails++; $display("FAIL err_rst: %0d m_rst pulses, required %0d", rst_pulses - base_rst, exp_rst); end
    endtask

    task automatic test_timeout();
        int d, lat;
        fill_rom();
        err_plan[0] = 99;
        never_busy = 1;
        build_model();
        run_seq();
        never_busy = 0;
        lat = int'((rst_t - 10 - start_t) / 10);
        checks++;
        if (lat < TMO || lat > TMO + 2) begin fails++; $display("FAIL timeout_len: m_start to m_rst %0d cycles, required %0d..%0d", lat, TMO, TMO + 2); end
        d = first_diff(base_iss);
        checks++;
        if (d != -1) begin fails++; $display("FAIL timeout_issue: first bad entry %0d of %0d issued, required none", d, issued.size() - base_iss); end
        checks++;
        if ({bus.fail, bus.active, bus.fail_index} !== {1'b1, 1'b0, AW'(0)}) begin fails++; $display("FAIL timeout_status: fail/active=%b%b index=%0d, required 10 index=0", bus.fail, bus.active, bus.fail_index); end
        checks++;
        if (rst_pulses - base_rst != exp_rst) begin fails++; $display("FAIL timeout_rst: %0d m_rst pulses, required %0d", rst_pulses - base_rst, exp_rst); end
    endtask

    task automatic test_go_and_reset();
        int i;
        fill_rom();
        seq_id++;
        base_iss = issued.size();
        @(negedge clk);
        bus.go = 1'b1;
        go_t = $time;
        @(negedge clk);
        bus.go = 1'b0;
        for (i = 0; i < 1000 && issued.size() < base_iss + 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.active !== 1'b1) begin fails++; $display("FAIL mid_active: active=%b, required 1", bus.active); end
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        for (i = 0; i < 1000 && issued.size() < base_iss + 3; i++) @(negedge clk);
        checks++;
        if (issued.size() < base_iss + 3 || issued[base_iss + 2] !== rom[2][14:0]) begin
            fails++;
            $display("FAIL go_ignored: third issue %h (count %0d), required %h", issued.size() >= base_iss + 3 ? issued[base_iss + 2] : 15'h0, issued.size() - base_iss, rom[2][14:0]);
        end
        for (i = 0; i < 100 && !bus.m_busy; i++) begin @(negedge clk); #1; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_addr, bus.m_start, bus.m_slave_addr, bus.m_data, bus.m_rst, bus.active,
             bus.done, bus.fail, bus.fail_index} !== 28'h0) begin
            fails++;
            $display("FAIL abort_values: outputs=%h, required 0", {bus.cmd_addr, bus.m_start, bus.m_slave_addr,
                     bus.m_data, bus.m_rst, bus.active, bus.done, bus.fail, bus.fail_index});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_last();
        int d;
        fill_rom();
        build_model();
        run_seq();
        d = first_diff(base_iss);
        checks++;
        if (d != -1) begin fails++; $display("FAIL nolast_issue: first bad entry %0d of %0d issued, required none", d, issued.size() - base_iss); end
        checks++;
        if ({bus.done, bus.fail, bus.active, bus.cmd_addr} !== {1'b1, 1'b0, 1'b0, AW'(NUM - 1)}) begin
            fails++;
            $display("FAIL nolast_status: done/fail/active=%b%b%b cmd_addr=%0d, required 100 cmd_addr=%0d", bus.done, bus.fail, bus.active, bus.cmd_addr, NUM - 1);
        end
    endtask

    initial begin
        bus.go = 1'b0;
        bus.m_busy = 1'b0;
        bus.m_error = 1'b0;
        never_busy = 0;
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    bus.m_busy = 1'b0;
                    bus.m_error = 1'b0;
                    phase = 0;
                    prev_start = 0;
                    rst_len = 0;
                end else begin
                    if (bus.m_start) begin
                        checks++;
                        if (prev_start) begin fails++; $display("FAIL start_width: m_start high 2 cycles, required 1"); end
                        issued.push_back({bus.m_slave_addr, bus.m_data});
                        ref_t = (ok_t > rst_t) ? ok_t : rst_t;
                        if (ref_t > start_t && ref_t > go_t) begin
                            gap = int'(($time - ref_t) / 10);
                            exp_gap = (ref_t == rst_t) ? GAP + 1 : GAP + 3;
                            checks++;
                            if (gap != exp_gap) begin fails++; $display("FAIL gap: %0d cycles to next start, required %0d", gap, exp_gap); end
                        end
                        if (start_t < go_t) first_start_t = $time;
                        start_t = $time;
                    end
                    prev_start = bus.m_start;
                    if (bus.m_rst) rst_len++;
                    else if (rst_len != 0) begin
                        checks++;
                        if (rst_len != 2) begin fails++; $display("FAIL rst_width: m_rst high %0d cycles, required 2", rst_len); end
                        rst_pulses++;
                        rst_t = $time - 10;
                        rst_len = 0;
                    end
                    checks++;
                    if (bus.cmd_addr > AW'(NUM - 1)) begin fails++; $display("FAIL addr_bound: cmd_addr=%0d, required <= %0d", bus.cmd_addr, NUM - 1); end
                    if (bus.m_rst) begin
                        bus.m_busy = 1'b0;
                        bus.m_error = 1'b0;
                        phase = 0;
                    end else case (phase)
                        0: if (bus.m_start) begin
                            if (seq_id != last_seq) begin
                                foreach (att[k]) att[k] = 0;
                                last_seq = seq_id;
                            end
                            err_this = att[bus.cmd_addr] < err_plan[bus.cmd_addr];
                            att[bus.cmd_addr]++;
                            hold = $urandom_range(1, 5);
                            t = 0;
                            phase = 1;
                        end
                        1: begin
                            t++;
                            if (t == 2 && !never_busy) begin
                                bus.m_busy = 1'b1;
                                t = 0;
                                phase = 2;
                            end
                        end
                        2: begin
                            t++;
                            if (t >= hold) begin
                                if (err_this) begin
                                    bus.m_error = 1'b1;
                                    phase = 3;
                                end else begin
                                    bus.m_busy = 1'b0;
                                    ok_t = $time;
                                    phase = 0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        join_none
        #1 rst_n = 1'b0;
        test_reset();
        test_three_cmds();
        test_retry();
        test_always_error();
        test_timeout();
        test_go_and_reset();
        test_no_last();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
